// File: rtl/tpu_pkg.sv
// Shared types and constants for the 4x4 systolic MAC array and its sequencer.
// Pure declarations: no latency, no flow control.
package tpu_pkg;

    localparam int ARR_DIM   = 4;
    localparam int DRAIN_CYC = 2 * ARR_DIM - 1;
    localparam int DRAIN_W   = $clog2(DRAIN_CYC);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/systolic_seq_ctrl_skew_line.sv
// Per-lane skew delay line feeding one edge of the systolic array.
// Latency: DEPTH cycles (DEPTH=0 is a wire); hold=1 freezes the whole line.
module skew_line #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ctl;
        assign unused_ctl = ^{clk, rst, hold};
        assign dout = din;
    end else begin : g_pipe
        logic [DEPTH-1:0][DATA_W-1:0] pipe;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pipe <= '0;
            end else if (!hold) begin
                pipe[0] <= din;
                for (int i = 1; i < DEPTH; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end

        assign dout = pipe[DEPTH-1];
    end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for the 4x4 output-stationary MAC array: clear, feed K skewed slices, drain, done.
// Latency: start->done = K+9 cycles; optional stall (SYSTOLIC_SEQ_STALL_EN) freezes FEED/DRAIN progress.
module systolic_seq_ctrl
    import tpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int K_MAX  = 16,
    parameter int K_W    = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [K_W-1:0]            k_len,
`ifdef SYSTOLIC_SEQ_STALL_EN
    input  logic                      stall,
`endif
    output logic                      busy,
    output logic                      done,
    output logic                      buf_rd_en,
    output logic [K_W-1:0]            buf_rd_addr,
    input  logic [ARR_DIM*DATA_W-1:0] a_col,
    input  logic [ARR_DIM*DATA_W-1:0] b_row,
    output logic                      arr_clr,
    output logic                      arr_en,
    output logic [ARR_DIM*DATA_W-1:0] a_west,
    output logic [ARR_DIM*DATA_W-1:0] b_north
);

    seq_state_t         state, state_nxt;
    logic [K_W-1:0]     k_q, k_nxt;
    logic [K_W-1:0]     addr_q, addr_nxt;
    logic [DRAIN_W-1:0] drain_q, drain_nxt;
    logic               vld_q;
    logic               stall_eff;
    logic [K_W-1:0]     k_clamped;

`ifdef SYSTOLIC_SEQ_STALL_EN
    assign stall_eff = stall && ((state == FEED) || (state == DRAIN));
`else
    assign stall_eff = 1'b0;
`endif

    assign k_clamped   = (k_len > K_W'(K_MAX)) ? K_W'(K_MAX) : k_len;
    assign buf_rd_addr = addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            k_q     <= '0;
            addr_q  <= '0;
            drain_q <= '0;
        end else begin
            state   <= state_nxt;
            k_q     <= k_nxt;
            addr_q  <= addr_nxt;
            drain_q <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        k_nxt     = k_q;
        addr_nxt  = addr_q;
        drain_nxt = drain_q;
        busy      = 1'b1;
        done      = 1'b0;
        buf_rd_en = 1'b0;
        arr_clr   = 1'b0;
        arr_en    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    k_nxt     = k_clamped;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                arr_clr   = 1'b1;
                addr_nxt  = '0;
                drain_nxt = '0;
                state_nxt = (k_q != '0) ? FEED : DONE;
            end
            FEED: begin
                if (!stall_eff) begin
                    buf_rd_en = 1'b1;
                    arr_en    = 1'b1;
                    if (addr_q == k_q - K_W'(1)) begin
                        addr_nxt  = '0;
                        state_nxt = DRAIN;
                    end else begin
                        addr_nxt = addr_q + K_W'(1);
                    end
                end
            end
            DRAIN: begin
                // Drain until the last slice has crossed to PE(3,3).
                if (!stall_eff) begin
                    arr_en = 1'b1;
                    if (drain_q == DRAIN_W'(DRAIN_CYC - 1)) begin
                        drain_nxt = '0;
                        state_nxt = DONE;
                    end else begin
                        drain_nxt = drain_q + DRAIN_W'(1);
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Buffer data is valid the cycle after the read strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
        end else if (!stall_eff) begin
            vld_q <= buf_rd_en;
        end
    end

    for (genvar r = 0; r < ARR_DIM; r++) begin : g_lane
        logic [DATA_W-1:0] a_gated;
        logic [DATA_W-1:0] b_gated;

        assign a_gated = vld_q ? a_col[r*DATA_W +: DATA_W] : '0;
        assign b_gated = vld_q ? b_row[r*DATA_W +: DATA_W] : '0;

        skew_line #(
            .DATA_W(DATA_W),
            .DEPTH (r)
        ) u_a_skew (
            .clk (clk),
            .rst (rst),
            .hold(stall_eff),
            .din (a_gated),
            .dout(a_west[r*DATA_W +: DATA_W])
        );

        skew_line #(
            .DATA_W(DATA_W),
            .DEPTH (r)
        ) u_b_skew (
            .clk (clk),
            .rst (rst),
            .hold(stall_eff),
            .din (b_gated),
            .dout(b_north[r*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: operand buffer and 4x4 MAC array reference models around the sequencer.
// Directed job table plus hand sequences for restart, mid-job reset and (optionally) stall.
module tb_systolic_seq_ctrl;

    localparam int DATA_W = 8;
    localparam int K_MAX  = 16;
    localparam int K_W    = 5;
    localparam int P_ONE_TWO = 0;
    localparam int P_IDENT   = 1;
    localparam int P_ONES    = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [K_W-1:0]    k_len = '0;
`ifdef SYSTOLIC_SEQ_STALL_EN
    logic              stall = 1'b0;
`endif
    logic              busy, done, buf_rd_en, arr_clr, arr_en;
    logic [K_W-1:0]    buf_rd_addr;
    logic [4*DATA_W-1:0] a_col = '0;
    logic [4*DATA_W-1:0] b_row = '0;
    logic [4*DATA_W-1:0] a_west, b_north;

    systolic_seq_ctrl #(.DATA_W(DATA_W), .K_MAX(K_MAX), .K_W(K_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .k_len      (k_len),
`ifdef SYSTOLIC_SEQ_STALL_EN
        .stall      (stall),
`endif
        .busy       (busy),
        .done       (done),
        .buf_rd_en  (buf_rd_en),
        .buf_rd_addr(buf_rd_addr),
        .a_col      (a_col),
        .b_row      (b_row),
        .arr_clr    (arr_clr),
        .arr_en     (arr_en),
        .a_west     (a_west),
        .b_north    (b_north)
    );

    always #5 clk = ~clk;

    // Operand buffer: amem[k][r] = A[r][k], bmem[k][c] = B[k][c]; 1-cycle read, holds last data.
    logic [DATA_W-1:0] amem [K_MAX][4];
    logic [DATA_W-1:0] bmem [K_MAX][4];
    logic              rd_s;
    logic [K_W-1:0]    addr_s;

    always @(negedge clk) begin
        rd_s   <= buf_rd_en;
        addr_s <= buf_rd_addr;
    end

    always @(posedge clk) begin
        if (rd_s) begin
            a_col <= {amem[addr_s][3], amem[addr_s][2], amem[addr_s][1], amem[addr_s][0]};
            b_row <= {bmem[addr_s][3], bmem[addr_s][2], bmem[addr_s][1], bmem[addr_s][0]};
        end
    end

    // Reference output-stationary array, evaluated mid-cycle on stable DUT outputs.
    int                acc [4][4];
    logic [DATA_W-1:0] ah  [4][4];
    logic [DATA_W-1:0] bv  [4][4];

    function automatic logic [DATA_W-1:0] a_in(input int r, input int c);
        return (c == 0) ? a_west[r*DATA_W +: DATA_W] : ah[r][c-1];
    endfunction

    function automatic logic [DATA_W-1:0] b_in(input int r, input int c);
        return (r == 0) ? b_north[c*DATA_W +: DATA_W] : bv[r-1][c];
    endfunction

    always @(negedge clk) begin
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (arr_clr) begin
                    acc[r][c] <= 0;
                    ah[r][c]  <= '0;
                    bv[r][c]  <= '0;
                end else if (arr_en) begin
                    acc[r][c] <= acc[r][c] + int'(a_in(r, c)) * int'(b_in(r, c));
                    ah[r][c]  <= a_in(r, c);
                    bv[r][c]  <= b_in(r, c);
                end
            end
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " busy"},        longint'(busy), 0);
        check({tag, " done"},        longint'(done), 0);
        check({tag, " buf_rd_en"},   longint'(buf_rd_en), 0);
        check({tag, " buf_rd_addr"}, longint'(buf_rd_addr), 0);
        check({tag, " arr_clr"},     longint'(arr_clr), 0);
        check({tag, " arr_en"},      longint'(arr_en), 0);
        check({tag, " a_west"},      longint'(a_west), 0);
        check({tag, " b_north"},     longint'(b_north), 0);
    endtask

    task automatic load_pattern(input int pat);
        for (int k = 0; k < K_MAX; k++) begin
            for (int i = 0; i < 4; i++) begin
                case (pat)
                    P_ONE_TWO: begin amem[k][i] = 8'd1; bmem[k][i] = 8'd2; end
                    P_IDENT:   begin amem[k][i] = (i == k) ? 8'd1 : 8'd0; bmem[k][i] = 8'(10 * k + i); end
                    default:   begin amem[k][i] = 8'd1; bmem[k][i] = 8'd1; end
                endcase
            end
        end
    endtask

    int done_cyc, done_cnt, clr_cyc, clr_cnt, rd_cnt, aw3_first, bn2_first;

    // Called at posedge+1; cycle rel=0 is the start cycle. Returns at posedge+1 of cycle `bound`.
    task automatic run_job(input int k, input int pat, input logic [31:0] smask,
                           input int restart_rel, input int rst_rel, input int bound);
        load_pattern(pat);
        done_cyc = -1; done_cnt = 0; clr_cyc = -1; clr_cnt = 0;
        rd_cnt = 0; aw3_first = -1; bn2_first = -1;
        k_len = K_W'(k);
        for (int rel = 0; rel < bound; rel++) begin
            start = (rel == 0) || (rel == restart_rel);
`ifdef SYSTOLIC_SEQ_STALL_EN
            stall = smask[rel];
`endif
            rst = (rel == rst_rel);
            if (rel == rst_rel) begin
                #1;
                check_zero_outputs("async_rst");
            end
            @(negedge clk);
            if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = rel; end
            if (arr_clr) begin clr_cnt++; if (clr_cyc < 0) clr_cyc = rel; end
            if (buf_rd_en) rd_cnt++;
            if (aw3_first < 0 && a_west[31:24] != 8'd0) aw3_first = rel;
            if (bn2_first < 0 && b_north[23:16] != 8'd0) bn2_first = rel;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        rst   = 1'b0;
`ifdef SYSTOLIC_SEQ_STALL_EN
        stall = 1'b0;
`endif
    endtask

    task automatic check_sums(input string tag, input int base, input int rm, input int cm);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                check($sformatf("%s sum[%0d][%0d]", tag, r, c), acc[r][c], base + rm * r + cm * c);
            end
        end
    endtask

    typedef struct {
        int k;
        int pat;
        int exp_done;
        int exp_rd;
        int exp_aw3;
        int exp_bn2;
        int base;
        int rm;
        int cm;
    } vec_t;

    vec_t vecs [5];

    initial begin
        //         k   pattern    done rd  aw3 bn2 base rm  cm
        vecs[0] = '{4,  P_ONE_TWO, 13,  4,  6,  5,  8,  0,  0};
        vecs[1] = '{4,  P_IDENT,   13,  4,  9,  5,  0, 10,  1};
        vecs[2] = '{0,  P_ONES,     2,  0, -1, -1,  0,  0,  0};
        vecs[3] = '{16, P_ONES,    25, 16,  6,  5, 16,  0,  0};
        vecs[4] = '{20, P_ONES,    25, 16,  6,  5, 16,  0,  0};

        #1;
        check_zero_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle busy", longint'(busy), 0);
        check("idle done", longint'(done), 0);
        @(posedge clk);
        #1;

        // Each job starts the cycle after the previous done.
        for (int v = 0; v < 5; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            run_job(vecs[v].k, vecs[v].pat, 32'd0, -1, -1, vecs[v].exp_done + 1);
            check({tag, " done_cycle"}, done_cyc, vecs[v].exp_done);
            check({tag, " done_count"}, done_cnt, 1);
            check({tag, " clr_cycle"}, clr_cyc, 1);
            check({tag, " clr_count"}, clr_cnt, 1);
            check({tag, " rd_count"}, rd_cnt, vecs[v].exp_rd);
            check({tag, " a_west3_first"}, aw3_first, vecs[v].exp_aw3);
            check({tag, " b_north2_first"}, bn2_first, vecs[v].exp_bn2);
            check_sums(tag, vecs[v].base, vecs[v].rm, vecs[v].cm);
        end

        run_job(4, P_ONE_TWO, 32'd0, 3, -1, 20);
        check("restart done_cycle", done_cyc, 13);
        check("restart done_count", done_cnt, 1);
        check("restart rd_count", rd_cnt, 4);
        check_sums("restart", 8, 0, 0);

        run_job(4, P_ONE_TWO, 32'd0, -1, 8, 20);
        check("rst_drain done_count", done_cnt, 0);
        check("rst_drain idle busy", longint'(busy), 0);

        run_job(4, P_IDENT, 32'd0, -1, -1, 14);
        check("post_rst done_cycle", done_cyc, 13);
        check("post_rst done_count", done_cnt, 1);
        check_sums("post_rst", 0, 10, 1);

`ifdef SYSTOLIC_SEQ_STALL_EN
        run_job(4, P_IDENT, 32'h0000_0C38, -1, -1, 22);
        check("stall done_cycle", done_cyc, 18);
        check("stall done_count", done_cnt, 1);
        check("stall rd_count", rd_cnt, 4);
        check_sums("stall", 0, 10, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
